// File: rtl/uart_rx_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
//   uart_rx_state_t  - receiver FSM state encoding
//   UART_DATA_BITS   - data bits per frame
//   uart_even_parity - even-parity bit for one data byte
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    UART_RX_IDLE       = 3'd0,
    UART_RX_START_BIT  = 3'd1,
    UART_RX_DATA_BIT   = 3'd2,
    UART_RX_PARITY_BIT = 3'd3,
    UART_RX_STOP_BIT   = 3'd4,
    UART_RX_BREAK      = 3'd5
  } uart_rx_state_t;

  // Bit that makes the total count of ones (data + parity) even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// axis_interface: minimal AXI Stream byte channel.
//   tdata[7:0] - payload byte
//   tvalid     - source holds a byte
//   tready     - sink accepts the byte this cycle
// Modports: Source (drives tdata/tvalid), Sink (drives tready).
interface axis_interface;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport Source (output tdata, output tvalid, input tready);
  modport Sink   (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line into the clk domain.
//   clk     - system clock
//   reset   - asynchronous active-low reset; chain resets to 1 (idle line)
//   rxd_i   - raw serial input
//   rxs_o   - synchronized line level
//   fall_o  - one-cycle strobe when rxs_o goes 1 -> 0
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rxd_i,
  output logic rxs_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd_i};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxs_o  = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding an AXI Stream source.
//   clk          - system clock, also the rx_stream clock
//   reset        - asynchronous active-low reset
//   rxd          - asynchronous serial input, idles high
//   rx_stream    - axis_interface.Source carrying received bytes
//   framing_err  - 1-cycle pulse: stop bit sampled low
//   overrun_err  - 1-cycle pulse: byte completed while output register full
//   parity_err   - (UART_RX_PARITY_EN only) 1-cycle pulse: bad even parity
// Build option: define UART_RX_PARITY_EN for 8E1 framing with a parity
// check; otherwise the receiver is 8N1 only.
// Parameters: CLKS_PER_BIT (>= 4), SYNC_STAGES (>= 2).
//
// state              | meaning
// UART_RX_IDLE       | line idle, waiting for a falling edge
// UART_RX_START_BIT  | half-bit wait, confirm start bit is still low
// UART_RX_DATA_BIT   | sample 8 data bits at mid-bit, LSB first
// UART_RX_PARITY_BIT | sample the even-parity bit (parity build only)
// UART_RX_STOP_BIT   | sample stop bit, deliver or drop the byte
// UART_RX_BREAK      | line held low after a framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rxd,
  axis_interface.Source rx_stream,
  output logic          framing_err,
`ifdef UART_RX_PARITY_EN
  output logic          parity_err,
`endif
  output logic          overrun_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_BITS - 1);

  logic rxs;
  logic fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .rxd_i (rxd),
    .rxs_o (rxs),
    .fall_o(fall)
  );

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      fe_q, fe_d;
  logic                      oe_q, oe_d;
  logic                      parity_ok;
`ifdef UART_RX_PARITY_EN
  logic                      par_q, par_d;
  logic                      pe_q, pe_d;
`endif

  always_comb begin
    parity_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    parity_ok = (par_q == uart_even_parity(shift_q));
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    fe_d     = 1'b0;
    oe_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    pe_d     = 1'b0;
`endif

    // Handshake first: a byte loaded below in the same cycle overrides it,
    // which is what lets a simultaneous pop make room for the next byte.
    if (tvalid_q && rx_stream.tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      UART_RX_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = UART_RX_START_BIT;
        end
      end

      UART_RX_START_BIT: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = UART_RX_DATA_BIT;
            idx_d   = '0;
          end else begin
            state_d = UART_RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      UART_RX_DATA_BIT: begin
        if (cnt_q == BIT_TC) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = UART_RX_PARITY_BIT;
`else
            state_d = UART_RX_STOP_BIT;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      UART_RX_PARITY_BIT: begin
        if (cnt_q == BIT_TC) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = UART_RX_STOP_BIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      UART_RX_STOP_BIT: begin
        if (cnt_q == BIT_TC) begin
          cnt_d = '0;
          if (rxs) begin
            // Back to IDLE at mid-stop so the next start edge is not missed.
            state_d = UART_RX_IDLE;
            if (!parity_ok) begin
`ifdef UART_RX_PARITY_EN
              pe_d = 1'b1;
`endif
            end else if (!tvalid_q || rx_stream.tready) begin
              tdata_d  = shift_q;
              tvalid_d = 1'b1;
            end else begin
              oe_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = UART_RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      UART_RX_BREAK: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = UART_RX_IDLE;
        end
      end

      default: begin
        state_d = UART_RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= UART_RX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      fe_q     <= 1'b0;
      oe_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      pe_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      fe_q     <= fe_d;
      oe_q     <= oe_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      pe_q     <= pe_d;
`endif
    end
  end

  assign rx_stream.tdata  = tdata_q;
  assign rx_stream.tvalid = tvalid_q;
  assign framing_err      = fe_q;
  assign overrun_err      = oe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err       = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rxd = 1'b1;
  logic tready = 1'b1;
  logic framing_err, overrun_err;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  axis_interface rx_if ();
  assign rx_if.tready = tready;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_stream  (rx_if),
    .framing_err(framing_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int act_fe = 0, act_oe = 0, act_pe = 0;
  int exp_fe = 0, exp_oe = 0, exp_pe = 0;
  logic [7:0] held;
  logic stall_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, counts error pulses,
  // and checks that a stalled byte is held stable.
  always @(negedge clk) begin
    if (!reset) begin
      stall_v = 1'b0;
    end else begin
      if (framing_err) act_fe++;
      if (overrun_err) act_oe++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) act_pe++;
`endif
      if (rx_if.tvalid && !tready) begin
        if (stall_v) check("stall_tdata", {24'd0, rx_if.tdata}, {24'd0, held});
        held    = rx_if.tdata;
        stall_v = 1'b1;
      end else begin
        stall_v = 1'b0;
      end
      if (rx_if.tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", rx_if.tdata, $time);
        end else begin
          check("beat_tdata", {24'd0, rx_if.tdata}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Outcome of one frame from the line rules: 0 = byte delivered,
  // 1 = framing error, 2 = parity error. A bad stop bit dominates.
  function automatic int frame_outcome(input logic [7:0] data, input logic stop, input logic par);
    if (!stop) return 1;
`ifdef UART_RX_PARITY_EN
    if (par != uart_even_parity(data)) return 2;
`else
    if (par !== par) return 2;
`endif
    return 0;
  endfunction

  task automatic bit_time(input logic level);
    rxd = level;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(data[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par);
`endif
    bit_time(stop);
    rxd = 1'b1;
  endtask

  // Records the model's expectation for a frame (tready assumed free), then sends it.
  task automatic send_expect(input logic [7:0] data, input logic stop, input logic par);
    int o;
    o = frame_outcome(data, stop, par);
    if (o == 0) exp_q.push_back(data);
    else if (o == 1) exp_fe++;
    else exp_pe++;
    send_frame(data, stop, par);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_errs(input string name);
    check({name, "_framing_cnt"}, act_fe, exp_fe);
    check({name, "_overrun_cnt"}, act_oe, exp_oe);
    check({name, "_parity_cnt"}, act_pe, exp_pe);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, d;
    logic st, pr;
    int gap;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", rx_if.tvalid, 0);
    check("rst_tdata", rx_if.tdata, 0);
    check("rst_framing", framing_err, 0);
    check("rst_overrun", overrun_err, 0);
    reset = 1'b1;
    idle_bits(2);

    // Reset mid-frame: A5 cut off during data bit 4
    a = 8'hA5;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(a[i]);
    rxd = a[4];
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_tvalid", rx_if.tvalid, 0);
    check("midrst_framing", framing_err, 0);
    check("midrst_overrun", overrun_err, 0);
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_bits(2);
    send_expect(8'h3C, 1'b1, uart_even_parity(8'h3C));
    idle_bits(2);
    drain("midrst");
    check_errs("midrst");

    // Back-to-back frames
    send_expect(8'h55, 1'b1, uart_even_parity(8'h55));
    send_expect(8'h00, 1'b1, uart_even_parity(8'h00));
    send_expect(8'hFF, 1'b1, uart_even_parity(8'hFF));
    idle_bits(2);
    drain("b2b");
    check_errs("b2b");

    // Framing error then 3 bit times of break
    send_expect(8'h81, 1'b0, uart_even_parity(8'h81));
    rxd = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1;
    idle_bits(2);
    check_errs("framing");
    send_expect(8'h42, 1'b1, uart_even_parity(8'h42));
    idle_bits(2);
    drain("after_break");
    check_errs("after_break");

    // Start-bit glitch of 4 clocks
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_bits(3);
    check("glitch_no_beat", rx_if.tvalid, 0);
    check_errs("glitch");

    // Overrun: tready low, 11 is held and 22 is lost
    tready = 1'b0;
    send_expect(8'h11, 1'b1, uart_even_parity(8'h11));
    send_frame(8'h22, 1'b1, uart_even_parity(8'h22));
    exp_oe++;
    idle_bits(2);
    check("ovr_tvalid", rx_if.tvalid, 1);
    check("ovr_tdata", rx_if.tdata, 8'h11);
    check_errs("overrun");
    tready = 1'b1;
    drain("overrun");
    idle_bits(1);
    check("ovr_single_beat", rx_if.tvalid, 0);

    // Handshake race: tready rises for the cycle of B's stop-bit sample.
    // Start edge at E: stop sample at edge E+3+CPB/2+9*CPB.
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    tready = 1'b0;
    send_expect(a, 1'b1, uart_even_parity(a));
    exp_q.push_back(b);
    fork
      send_frame(b, 1'b1, uart_even_parity(b));
      begin
        repeat (3 + CPB / 2 + 9 * CPB - 1) @(posedge clk);
        #1;
        tready = 1'b1;
      end
    join
    idle_bits(2);
    drain("race");
    check_errs("race");

`ifdef UART_RX_PARITY_EN
    send_expect(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    send_expect(8'h07, 1'b1, 1'b0);
    idle_bits(2);
    drain("parity");
    check_errs("parity");
`endif

    // Randomized frames: random data, occasional bad stop/parity, random gaps
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 7) != 0);
      pr = uart_even_parity(d);
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 5) == 0) pr = ~pr;
`endif
      send_expect(d, st, pr);
      gap = $urandom_range(0, 2);
      if (!st && gap == 0) gap = 1;
      if (gap != 0) idle_bits(gap);
    end
    idle_bits(2);
    drain("random");
    check_errs("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
